// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: carries decode-stage register/control tags through the
// E, M and W stages for the hazard detection unit, applies bubble/freeze
// requests, and keeps stall/flush/retire statistics plus a stuck-pipe flag.
module hazard_tag_pipe #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_D,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rd_D,
    input  logic             regwrite_D,
    input  logic             memtoreg_D,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             branch_flush,
    input  logic             mem_stall,
    input  logic             clr_stats,
    output logic [4:0]       rs1_E,
    output logic [4:0]       rs2_E,
    output logic [4:0]       rd_E,
    output logic             regwrite_E,
    output logic             memtoreg_E,
    output logic [4:0]       rd_M,
    output logic             regwrite_M,
    output logic             memtoreg_M,
    output logic [4:0]       rd_W,
    output logic             regwrite_W,
    output logic             retire_W,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             stall_timeout
);

    localparam int              RUN_W   = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

    // Saturating increment: an all-ones counter stays put instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + CNT_W'(1);
        end
    endfunction

    // Stage registers
    logic             valid_e_r, valid_m_r, valid_w_r;
    logic [4:0]       rs1_e_r, rs2_e_r, rd_e_r, rd_m_r, rd_w_r;
    logic             regwrite_e_r, memtoreg_e_r;
    logic             regwrite_m_r, memtoreg_m_r;
    logic             regwrite_w_r;

    // Statistics registers
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r, retire_cnt_r;
    logic [RUN_W-1:0] run_r;
    logic             timeout_r;

    // Decode-side next values
    logic             flush_s, stall_any_s, keep_s, rd_zero_s;
    logic             e_valid_s, e_regwrite_s, e_memtoreg_s;
    logic [4:0]       e_rs1_s, e_rs2_s, e_rd_s;
    logic [RUN_W-1:0] run_next_s;
    logic             timeout_hit_s;

    // Build the sanitised E-stage entry: a bubble when D is empty or being
    // flushed, and no write/load side effects for an x0 destination.
    always_comb begin
        flush_s      = FlushE | branch_flush;
        stall_any_s  = StallD | mem_stall;
        keep_s       = valid_D & ~flush_s;
        rd_zero_s    = (rd_D == 5'd0);
        e_valid_s    = 1'b0;
        e_rs1_s      = 5'd0;
        e_rs2_s      = 5'd0;
        e_rd_s       = 5'd0;
        e_regwrite_s = 1'b0;
        e_memtoreg_s = 1'b0;
        if (keep_s) begin
            e_valid_s    = 1'b1;
            e_rs1_s      = rs1_D;
            e_rs2_s      = rs2_D;
            e_rd_s       = rd_D;
            e_regwrite_s = regwrite_D & ~rd_zero_s;
            e_memtoreg_s = memtoreg_D & ~rd_zero_s;
        end else begin
            e_valid_s    = 1'b0;
        end
    end

    // Consecutive-stall run length, saturating at TIMEOUT.
    always_comb begin
        run_next_s = {RUN_W{1'b0}};
        if (!stall_any_s) begin
            run_next_s = {RUN_W{1'b0}};
        end else if (run_r == RUN_MAX) begin
            run_next_s = run_r;
        end else begin
            run_next_s = run_r + RUN_W'(1);
        end
        timeout_hit_s = stall_any_s & (run_next_s == RUN_MAX);
    end

    // Advance E/M/W unless data memory freezes the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e_r    <= 1'b0;
            rs1_e_r      <= 5'd0;
            rs2_e_r      <= 5'd0;
            rd_e_r       <= 5'd0;
            regwrite_e_r <= 1'b0;
            memtoreg_e_r <= 1'b0;
            valid_m_r    <= 1'b0;
            rd_m_r       <= 5'd0;
            regwrite_m_r <= 1'b0;
            memtoreg_m_r <= 1'b0;
            valid_w_r    <= 1'b0;
            rd_w_r       <= 5'd0;
            regwrite_w_r <= 1'b0;
        end else if (!mem_stall) begin
            valid_e_r    <= e_valid_s;
            rs1_e_r      <= e_rs1_s;
            rs2_e_r      <= e_rs2_s;
            rd_e_r       <= e_rd_s;
            regwrite_e_r <= e_regwrite_s;
            memtoreg_e_r <= e_memtoreg_s;
            valid_m_r    <= valid_e_r;
            rd_m_r       <= rd_e_r;
            regwrite_m_r <= regwrite_e_r;
            memtoreg_m_r <= memtoreg_e_r;
            valid_w_r    <= valid_m_r;
            rd_w_r       <= rd_m_r;
            regwrite_w_r <= regwrite_m_r;
        end else begin
            valid_e_r    <= valid_e_r;
            valid_m_r    <= valid_m_r;
            valid_w_r    <= valid_w_r;
        end
    end

    // Event counters and sticky stuck-pipe flag; clr_stats beats any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
            retire_cnt_r <= {CNT_W{1'b0}};
            run_r        <= {RUN_W{1'b0}};
            timeout_r    <= 1'b0;
        end else if (clr_stats) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
            retire_cnt_r <= {CNT_W{1'b0}};
            run_r        <= {RUN_W{1'b0}};
            timeout_r    <= 1'b0;
        end else begin
            if (stall_any_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (!mem_stall && flush_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
            if (!mem_stall && valid_w_r) begin
                retire_cnt_r <= sat_inc(retire_cnt_r);
            end
            run_r     <= run_next_s;
            timeout_r <= timeout_r | timeout_hit_s;
        end
    end

    assign rs1_E         = rs1_e_r;
    assign rs2_E         = rs2_e_r;
    assign rd_E          = rd_e_r;
    assign regwrite_E    = regwrite_e_r;
    assign memtoreg_E    = memtoreg_e_r;
    assign rd_M          = rd_m_r;
    assign regwrite_M    = regwrite_m_r;
    assign memtoreg_M    = memtoreg_m_r;
    assign rd_W          = rd_w_r;
    assign regwrite_W    = regwrite_w_r;
    assign retire_W      = valid_w_r;
    assign stall_cnt     = stall_cnt_r;
    assign flush_cnt     = flush_cnt_r;
    assign retire_cnt    = retire_cnt_r;
    assign stall_timeout = timeout_r;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed bench for hazard_tag_pipe: a vector table for single-cycle
// capture rules plus hand sequences for stall, freeze, timeout and reset.
module tb_hazard_tag_pipe;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mtr;
    } stg_t;

    typedef struct {
        stg_t d;
        logic stl;
        logic fe;
        logic bf;
        stg_t e;
    } vec_t;

    logic        clk, rst_n;
    logic        valid_D, regwrite_D, memtoreg_D;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic        StallD, FlushE, branch_flush, mem_stall, clr_stats;
    logic [4:0]  rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic        regwrite_E, memtoreg_E, regwrite_M, memtoreg_M, regwrite_W, retire_W;
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;
    logic        stall_timeout;

    int tests  = 0;
    int failed = 0;

    hazard_tag_pipe #(.CNT_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
        .regwrite_D(regwrite_D), .memtoreg_D(memtoreg_D),
        .StallD(StallD), .FlushE(FlushE), .branch_flush(branch_flush),
        .mem_stall(mem_stall), .clr_stats(clr_stats),
        .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .regwrite_E(regwrite_E), .memtoreg_E(memtoreg_E),
        .rd_M(rd_M), .regwrite_M(regwrite_M), .memtoreg_M(memtoreg_M),
        .rd_W(rd_W), .regwrite_W(regwrite_W), .retire_W(retire_W),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt),
        .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic stg_t st(input logic v, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] d, input logic rw, input logic mtr);
        stg_t s;
        s.v = v; s.rs1 = a; s.rs2 = b; s.rd = d; s.rw = rw; s.mtr = mtr;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input stg_t s);
        valid_D = s.v; rs1_D = s.rs1; rs2_D = s.rs2; rd_D = s.rd;
        regwrite_D = s.rw; memtoreg_D = s.mtr;
    endtask

    task automatic check_pipe(input stg_t e, input stg_t m, input stg_t w);
        chk("rs1_E", rs1_E, e.rs1);
        chk("rs2_E", rs2_E, e.rs2);
        chk("rd_E", rd_E, e.rd);
        chk("regwrite_E", regwrite_E, e.rw);
        chk("memtoreg_E", memtoreg_E, e.mtr);
        chk("rd_M", rd_M, m.rd);
        chk("regwrite_M", regwrite_M, m.rw);
        chk("memtoreg_M", memtoreg_M, m.mtr);
        chk("rd_W", rd_W, w.rd);
        chk("regwrite_W", regwrite_W, w.rw);
        chk("retire_W", retire_W, w.v);
    endtask

    vec_t vecs[9];
    stg_t bub, exp_e, exp_m, exp_w;
    int   st_exp, fl_exp, rt_exp;

    initial begin
        bub = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        //              d                                              stl   fe    bf    expected E
        vecs[0] = '{st(1'b1, 5'd1,  5'd2,  5'd5,  1'b1, 1'b0), 1'b0, 1'b0, 1'b0, st(1'b1, 5'd1,  5'd2,  5'd5,  1'b1, 1'b0)};
        vecs[1] = '{st(1'b1, 5'd3,  5'd4,  5'd0,  1'b1, 1'b1), 1'b0, 1'b0, 1'b0, st(1'b1, 5'd3,  5'd4,  5'd0,  1'b0, 1'b0)};
        vecs[2] = '{st(1'b0, 5'd6,  5'd7,  5'd8,  1'b1, 1'b1), 1'b0, 1'b0, 1'b0, bub};
        vecs[3] = '{st(1'b1, 5'd9,  5'd10, 5'd11, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0, bub};
        vecs[4] = '{st(1'b1, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, bub};
        vecs[5] = '{st(1'b1, 5'd15, 5'd16, 5'd17, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, st(1'b1, 5'd15, 5'd16, 5'd17, 1'b0, 1'b1)};
        vecs[6] = '{st(1'b1, 5'd18, 5'd19, 5'd20, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0, st(1'b1, 5'd18, 5'd19, 5'd20, 1'b1, 1'b0)};
        vecs[7] = '{st(1'b1, 5'd21, 5'd22, 5'd23, 1'b1, 1'b1), 1'b0, 1'b1, 1'b1, bub};
        vecs[8] = '{st(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, st(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1)};

        rst_n = 1'b0;
        drive_d(bub);
        StallD = 1'b0; FlushE = 1'b0; branch_flush = 1'b0; mem_stall = 1'b0; clr_stats = 1'b0;
        #2;
        check_pipe(bub, bub, bub);
        chk("reset stall_cnt", stall_cnt, 32'd0);
        chk("reset flush_cnt", flush_cnt, 32'd0);
        chk("reset retire_cnt", retire_cnt, 32'd0);
        chk("reset stall_timeout", stall_timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: capture rules, with M/W following the expected E history.
        exp_e = bub; exp_m = bub; exp_w = bub;
        st_exp = 0; fl_exp = 0; rt_exp = 0;
        for (int i = 0; i < 9; i++) begin
            drive_d(vecs[i].d);
            StallD = vecs[i].stl; FlushE = vecs[i].fe; branch_flush = vecs[i].bf;
            if (vecs[i].stl && !vecs[i].fe)
                $display("[TB] note: vector %0d applies StallD without FlushE", i);
            if (exp_w.v) rt_exp++;
            if (vecs[i].stl) st_exp++;
            if (vecs[i].fe || vecs[i].bf) fl_exp++;
            exp_w = exp_m; exp_m = exp_e; exp_e = vecs[i].e;
            tick();
            check_pipe(exp_e, exp_m, exp_w);
            chk("table retire_cnt", retire_cnt, rt_exp);
        end
        chk("table stall_cnt", stall_cnt, st_exp);
        chk("table flush_cnt", flush_cnt, fl_exp);
        StallD = 1'b0; FlushE = 1'b0; branch_flush = 1'b0;

        // Load-use: load rd=7 reaches E, then a stall+bubble cycle.
        clr_stats = 1'b1;
        drive_d(st(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1));
        tick();
        clr_stats = 1'b0;
        chk("lu rd_E load", rd_E, 5'd7);
        chk("lu memtoreg_E load", memtoreg_E, 1'b1);
        drive_d(st(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0));
        StallD = 1'b1; FlushE = 1'b1;
        tick();
        StallD = 1'b0; FlushE = 1'b0;
        chk("lu rd_E bubble", rd_E, 5'd0);
        chk("lu regwrite_E bubble", regwrite_E, 1'b0);
        chk("lu rd_M", rd_M, 5'd7);
        chk("lu memtoreg_M", memtoreg_M, 1'b1);
        chk("lu stall_cnt", stall_cnt, 32'd1);
        chk("lu flush_cnt", flush_cnt, 32'd1);
        tick();
        chk("lu rd_E dependent", rd_E, 5'd8);
        chk("lu rd_W load", rd_W, 5'd7);

        // Memory freeze with a full pipe (E/M/W = 3/2/1).
        drive_d(bub);
        for (int i = 0; i < 3; i++) tick();
        clr_stats = 1'b1;
        drive_d(st(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0));
        tick();
        clr_stats = 1'b0;
        drive_d(st(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0));
        tick();
        drive_d(st(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0));
        tick();
        drive_d(st(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0));
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            branch_flush = (i == 1);
            tick();
            check_pipe(st(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0),
                       st(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0),
                       st(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0));
        end
        branch_flush = 1'b0;
        chk("freeze stall_cnt", stall_cnt, 32'd4);
        chk("freeze flush_cnt", flush_cnt, 32'd0);
        chk("freeze retire_cnt", retire_cnt, 32'd0);
        mem_stall = 1'b0;
        drive_d(bub);
        tick();
        check_pipe(bub, st(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0),
                   st(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0));
        chk("thaw retire_cnt", retire_cnt, 32'd1);

        // Timeout: a broken run restarts the count; 8 consecutive cycles set it.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        StallD = 1'b1; FlushE = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        StallD = 1'b0; FlushE = 1'b0;
        tick();
        StallD = 1'b1; FlushE = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("timeout after 7", stall_timeout, 1'b0);
        tick();
        chk("timeout after 8", stall_timeout, 1'b1);
        chk("timeout stall_cnt", stall_cnt, 32'd13);
        StallD = 1'b0; FlushE = 1'b0;
        tick();
        chk("timeout sticky", stall_timeout, 1'b1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr stall_timeout", stall_timeout, 1'b0);
        chk("clr stall_cnt", stall_cnt, 32'd0);
        chk("clr flush_cnt", flush_cnt, 32'd0);
        chk("clr retire_cnt", retire_cnt, 32'd0);

        // Asynchronous reset between edges with a full pipe.
        for (int i = 1; i <= 3; i++) begin
            drive_d(st(1'b1, 5'd0, 5'd0, 5'(i), 1'b1, 1'b1));
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_pipe(bub, bub, bub);
        chk("async stall_cnt", stall_cnt, 32'd0);
        chk("async retire_cnt", retire_cnt, 32'd0);
        rst_n = 1'b1;
        drive_d(st(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0));
        tick();
        chk("post-reset rd_E", rd_E, 5'd9);
        chk("post-reset rd_M", rd_M, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
